// File: rtl/mch3d_cmd_pkg.sv
// mch3d_cmd_pkg
//   Shared definitions for the command path between the SPI command FIFO and
//   the render pipeline: opcode constants, the widest argument payload, the
//   parser state encoding and the opcode lookup result record.
package mch3d_cmd_pkg;

  // Widest argument payload any opcode may carry (bytes).
  localparam int MAX_ARGS = 8;

  // Opcode constants.
  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_CLEAR      = 8'h10;
  localparam logic [7:0] OP_VERTEX     = 8'h20;
  localparam logic [7:0] OP_TRIANGLE   = 8'h21;
  localparam logic [7:0] OP_MATRIX_ROW = 8'h30;
  localparam logic [7:0] OP_PIPE_RESET = 8'hFF;

  // Parser framing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARGS = 2'd1,
    EMIT = 2'd2
  } parser_state_t;

  // Result of an opcode lookup.
  typedef struct packed {
    logic       known;
    logic       nop;
    logic [3:0] length;
  } cmd_info_t;

endpackage

// File: rtl/cmd_length_lut.sv
// cmd_length_lut
//   Combinational opcode decoder returning whether the opcode is recognised,
//   whether it is the NOP filler, and how many argument bytes follow it.
//   Kept separate so other command consumers can share the same table.
// Ports:
//   opcode  in   8  opcode byte to classify
//   info    out  6  {known, nop, length[3:0]}
module cmd_length_lut
  import mch3d_cmd_pkg::*;
(
  input  logic [7:0] opcode,
  output cmd_info_t  info
);

  always_comb begin
    info = '{known: 1'b1, nop: 1'b0, length: 4'd0};
    case (opcode)
      OP_NOP:        info.nop    = 1'b1;
      OP_CLEAR:      info.length = 4'd3;
      OP_VERTEX:     info.length = 4'd6;
      OP_TRIANGLE:   info.length = 4'd0;
      OP_MATRIX_ROW: info.length = 4'd8;
      OP_PIPE_RESET: info.length = 4'd0;
      default:       info.known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/command_parser.sv
// command_parser
//   Pops bytes from the first-word-fall-through command FIFO, frames them into
//   opcode + fixed-length argument commands and presents each complete command
//   to the render pipeline on a valid/ready handshake. SPI chip-select framing
//   is invisible here, so a command may straddle CS frames.
//
//   Optional feature macro: CMD_TIMEOUT_EN
//     When defined, a command starved of argument bytes for TIMEOUT_CYCLES
//     cycles is dropped with a cmd_error pulse. When undefined, the parser
//     waits for argument bytes indefinitely.
//
// Ports:
//   clk          in   1           system clock
//   rst_n        in   1           asynchronous active-low reset
//   fifo_rddata  in   8           FIFO head byte, valid while fifo_empty=0
//   fifo_empty   in   1           FIFO empty flag
//   fifo_pop     out  1           consume head byte this cycle
//   cmd_valid    out  1           command available
//   cmd_ready    in   1           downstream accepts
//   cmd_opcode   out  8           opcode of presented command
//   cmd_args     out  MAX_ARGS*8  argument bytes, byte i at [8*i+:8], unused 0
//   cmd_nargs    out  4           number of valid argument bytes
//   cmd_error    out  1           one-cycle pulse on unknown opcode / timeout
module command_parser #(
  parameter int MAX_ARGS       = mch3d_cmd_pkg::MAX_ARGS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            fifo_rddata,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [7:0]            cmd_opcode,
  output logic [MAX_ARGS*8-1:0] cmd_args,
  output logic [3:0]            cmd_nargs,
  output logic                  cmd_error
);

  import mch3d_cmd_pkg::*;

  parser_state_t state;
  parser_state_t state_next;
  cmd_info_t     info;
  logic [3:0]    arg_cnt;
  logic          load_cmd;
  logic          store_arg;
  logic          error_next;

  cmd_length_lut u_lut (
    .opcode (fifo_rddata),
    .info   (info)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int STARVE_W = $clog2(TIMEOUT_CYCLES + 1);
  // Expiry fires on the starved cycle that would take the count to TIMEOUT_CYCLES.
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(TIMEOUT_CYCLES - 1);

  logic [STARVE_W-1:0] starve_cnt;

  // Counts consecutive starved cycles in ARGS; any pop or leaving ARGS clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == ARGS && fifo_empty) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and pop decision. The FIFO head is only consumed in IDLE and
  // ARGS so a pending command in EMIT back-pressures the FIFO.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    load_cmd   = 1'b0;
    store_arg  = 1'b0;
    error_next = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!info.nop) begin
            if (!info.known) begin
              error_next = 1'b1;
            end else begin
              load_cmd   = 1'b1;
              state_next = (info.length == 4'd0) ? EMIT : ARGS;
            end
          end
        end
      end
      ARGS: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          store_arg = 1'b1;
          if (arg_cnt == cmd_nargs - 4'd1) begin
            state_next = EMIT;
          end
        end
`ifdef CMD_TIMEOUT_EN
        else if (starve_cnt == STARVE_LIMIT) begin
          error_next = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      EMIT: begin
        if (cmd_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_valid = (state == EMIT);

  // Command datapath. A new opcode clears the whole argument field so bytes
  // past cmd_nargs always read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_error  <= 1'b0;
      cmd_opcode <= '0;
      cmd_args   <= '0;
      cmd_nargs  <= '0;
      arg_cnt    <= '0;
    end else begin
      cmd_error <= error_next;
      if (load_cmd) begin
        cmd_opcode <= fifo_rddata;
        cmd_args   <= '0;
        cmd_nargs  <= info.length;
        arg_cnt    <= '0;
      end else if (store_arg) begin
        for (int i = 0; i < MAX_ARGS; i++) begin
          if (arg_cnt == 4'(i)) begin
            cmd_args[8*i +: 8] <= fifo_rddata;
          end
        end
        arg_cnt <= arg_cnt + 4'd1;
      end
    end
  end

endmodule
